cache_refill_ctrl: RTL and testbench

//   Miss-refill stage directly upstream of the instruction cache. On a cache miss it

---
 rtl/cache_pkg.sv | 18 +
 rtl/refill_line_buffer.sv | 50 +++++
 rtl/cache_refill_ctrl.sv | 155 +++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache geometry and refill-stage state encoding, used by the refill
// controller and by the instruction cache itself.
package cache_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int WORD_BYTES  = 4;
    localparam int LINE_BYTES  = LINE_WORDS * WORD_BYTES;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    localparam logic [31:0] LINE_BASE_MASK = ~32'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_FETCH = 2'd1,
        REFILL_DONE  = 2'd2
    } refill_state_e;

endpackage

// File: rtl/refill_line_buffer.sv
// Shadow buffer for a line being refilled: words are written by index as they
// arrive, and the whole line is committed to data_line in one cycle on request.
module refill_line_buffer #(
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             wr_en,
    input  logic [IDX_W-1:0]                 wr_idx,
    input  logic [WORD_WIDTH-1:0]            wr_data,
    input  logic                             commit,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] data_line
);

    logic [LINE_WORDS*WORD_WIDTH-1:0] merged_line;
    logic [LINE_WORDS*WORD_WIDTH-1:0] data_line_reg;

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic                  hit;
            logic [WORD_WIDTH-1:0] word_reg;

            assign hit = wr_en && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    word_reg <= '0;
                end else if (hit) begin
                    word_reg <= wr_data;
                end
            end

            // The final word arrives on the commit cycle, so bypass it into the line.
            assign merged_line[gi*WORD_WIDTH +: WORD_WIDTH] = hit ? wr_data : word_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_line_reg <= '0;
        end else if (commit) begin
            data_line_reg <= merged_line;
        end
    end

    assign data_line = data_line_reg;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Instruction-cache miss refill: fetches the missing line word by word over a
// req/ack memory port and hands the assembled line to the cache with a strobe.
module cache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             miss_req,
    input  logic [ADDR_WIDTH-1:0]            miss_addr,
    input  logic                             flush,
    output logic                             mem_req,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic                             mem_ack,
    input  logic [WORD_WIDTH-1:0]            mem_rdata,
    output logic                             busy,
    output logic                             line_valid,
    output logic [ADDR_WIDTH-1:0]            line_addr,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] data_line,
    output logic                             refill_err
);

    import cache_pkg::*;

    localparam int CNT_W      = $clog2(LINE_WORDS);
    localparam int WAIT_W     = $clog2(TIMEOUT + 1);
    localparam int WORD_SHIFT = $clog2(WORD_WIDTH / 8);
    localparam int LINE_SPAN  = LINE_WORDS * (WORD_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_SPAN - 1);
    localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(LINE_WORDS - 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    refill_state_e         state_reg, state_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
    logic                  mem_req_reg, mem_req_next;
    logic [CNT_W-1:0]      word_cnt_reg, word_cnt_next;
    logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic                  line_valid_reg, line_valid_next;
    logic [ADDR_WIDTH-1:0] line_addr_reg, line_addr_next;
    logic                  refill_err_reg, refill_err_next;
    logic                  buf_wr_en;
    logic                  buf_commit;
    logic [CNT_W-1:0]      word_cnt_inc;
    logic [ADDR_WIDTH-1:0] miss_base;

    assign word_cnt_inc = word_cnt_reg + CNT_W'(1);
    assign miss_base    = miss_addr & LINE_MASK;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= REFILL_IDLE;
            base_reg       <= '0;
            mem_addr_reg   <= '0;
            mem_req_reg    <= 1'b0;
            word_cnt_reg   <= '0;
            wait_cnt_reg   <= '0;
            line_valid_reg <= 1'b0;
            line_addr_reg  <= '0;
            refill_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            mem_addr_reg   <= mem_addr_next;
            mem_req_reg    <= mem_req_next;
            word_cnt_reg   <= word_cnt_next;
            wait_cnt_reg   <= wait_cnt_next;
            line_valid_reg <= line_valid_next;
            line_addr_reg  <= line_addr_next;
            refill_err_reg <= refill_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        mem_addr_next   = mem_addr_reg;
        mem_req_next    = mem_req_reg;
        word_cnt_next   = word_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        line_valid_next = 1'b0;
        line_addr_next  = line_addr_reg;
        refill_err_next = 1'b0;
        buf_wr_en       = 1'b0;
        buf_commit      = 1'b0;

        case (state_reg)
            REFILL_IDLE: begin
                if (miss_req) begin
                    base_next     = miss_base;
                    mem_addr_next = miss_base;
                    mem_req_next  = 1'b1;
                    word_cnt_next = '0;
                    wait_cnt_next = '0;
                    state_next    = REFILL_FETCH;
                end
            end
            REFILL_FETCH: begin
                // Flush beats both a same-cycle ack and a timeout.
                if (flush) begin
                    mem_req_next = 1'b0;
                    state_next   = REFILL_IDLE;
                end else if (mem_ack) begin
                    buf_wr_en     = 1'b1;
                    wait_cnt_next = '0;
                    if (word_cnt_reg == LAST_WORD) begin
                        mem_req_next    = 1'b0;
                        buf_commit      = 1'b1;
                        line_addr_next  = base_reg;
                        line_valid_next = 1'b1;
                        state_next      = REFILL_DONE;
                    end else begin
                        word_cnt_next = word_cnt_inc;
                        mem_addr_next = base_reg | (ADDR_WIDTH'(word_cnt_inc) << WORD_SHIFT);
                    end
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    mem_req_next    = 1'b0;
                    refill_err_next = 1'b1;
                    state_next      = REFILL_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            REFILL_DONE: begin
                state_next = REFILL_IDLE;
            end
            default: begin
                state_next = REFILL_IDLE;
            end
        endcase
    end

    refill_line_buffer #(
        .WORD_WIDTH (WORD_WIDTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buffer (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (buf_wr_en),
        .wr_idx    (word_cnt_reg),
        .wr_data   (mem_rdata),
        .commit    (buf_commit),
        .data_line (data_line)
    );

    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign busy       = (state_reg != REFILL_IDLE);
    assign line_valid = line_valid_reg;
    assign line_addr  = line_addr_reg;
    assign refill_err = refill_err_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: zero-wait and wait-state fills, timeout,
// flush, miss while busy and asynchronous reset mid-refill.
module tb_cache_refill_ctrl;

    logic         clock;
    logic         reset_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         flush;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         busy;
    logic         line_valid;
    logic [31:0]  line_addr;
    logic [127:0] data_line;
    logic         refill_err;

    int checks = 0;
    int errors = 0;

    cache_refill_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .line_valid (line_valid),
        .line_addr  (line_addr),
        .data_line  (data_line),
        .refill_err (refill_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full zero-wait refill starting from IDLE; words are d0, d0+1, d0+2, d0+3.
    task automatic fill_zero_wait(input string name, input logic [31:0] addr,
                                  input logic [31:0] base, input logic [31:0] d0);
        logic [127:0] exp_line;
        exp_line = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
        miss_req  = 1'b1;
        miss_addr = addr;
        tick();
        miss_req = 1'b0;
        chk({name, " busy_fetch"}, busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s mem_req_w%0d", name, i), mem_req, 1'b1);
            chk($sformatf("%s mem_addr_w%0d", name, i), mem_addr, base + 32'(4 * i));
            chk($sformatf("%s no_valid_w%0d", name, i), line_valid, 1'b0);
            mem_ack   = 1'b1;
            mem_rdata = d0 + 32'(i);
            tick();
        end
        mem_ack = 1'b0;
        chk({name, " line_valid"}, line_valid, 1'b1);
        chk({name, " line_addr"}, line_addr, base);
        chk({name, " data_line"}, data_line, exp_line);
        chk({name, " mem_req_off"}, mem_req, 1'b0);
        tick();
        chk({name, " valid_drop"}, line_valid, 1'b0);
        chk({name, " idle"}, busy, 1'b0);
        $display("fill %s addr=%h line_addr=%h data_line=%h", name, addr, line_addr, data_line);
    endtask

    initial begin
        reset_n   = 1'b0;
        miss_req  = 1'b0;
        miss_addr = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        #3;
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst busy", busy, 1'b0);
        chk("rst line_valid", line_valid, 1'b0);
        chk("rst line_addr", line_addr, 32'h0);
        chk("rst data_line", data_line, 128'h0);
        chk("rst refill_err", refill_err, 1'b0);
        $display("reset: outputs checked");
        #4 reset_n = 1'b1;
        tick();

        // Zero-wait fill at 0x84
        fill_zero_wait("zero_wait", 32'h84, 32'h80, 32'hA0);
        chk("zw exact line", data_line, 128'h000000A3_000000A2_000000A1_000000A0);

        // Two wait cycles before each ack: line_valid after edge 12
        miss_req  = 1'b1;
        miss_addr = 32'h1AC;
        tick();
        miss_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 2; w++) begin
                tick();
                chk($sformatf("wait mem_addr_w%0d_c%0d", i, w), mem_addr, 32'h1A0 + 32'(4 * i));
                chk($sformatf("wait mem_req_w%0d_c%0d", i, w), mem_req, 1'b1);
                chk($sformatf("wait no_valid_w%0d_c%0d", i, w), line_valid, 1'b0);
            end
            mem_ack   = 1'b1;
            mem_rdata = 32'hB0 + 32'(i);
            tick();
            mem_ack = 1'b0;
        end
        chk("wait line_valid", line_valid, 1'b1);
        chk("wait line_addr", line_addr, 32'h1A0);
        chk("wait data_line", data_line, 128'h000000B3_000000B2_000000B1_000000B0);
        $display("wait-state fill: line_addr=%h data_line=%h", line_addr, data_line);
        tick();
        chk("wait idle", busy, 1'b0);

        // Timeout: only word 0 acknowledged
        miss_req  = 1'b1;
        miss_addr = 32'h40;
        tick();
        miss_req  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hC0;
        tick();
        mem_ack = 1'b0;
        chk("to mem_addr_w1", mem_addr, 32'h44);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk($sformatf("to no_err_c%0d", c), refill_err, 1'b0);
            chk($sformatf("to busy_c%0d", c), busy, 1'b1);
        end
        tick();
        chk("to refill_err", refill_err, 1'b1);
        chk("to mem_req", mem_req, 1'b0);
        chk("to busy", busy, 1'b0);
        chk("to line_valid", line_valid, 1'b0);
        chk("to data_line kept", data_line, 128'h000000B3_000000B2_000000B1_000000B0);
        chk("to line_addr kept", line_addr, 32'h1A0);
        $display("timeout: refill_err=%b busy=%b", refill_err, busy);
        tick();
        chk("to err_drop", refill_err, 1'b0);

        // Flush together with the ack of word 2
        miss_req  = 1'b1;
        miss_addr = 32'h500;
        tick();
        miss_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hD0 + 32'(i);
            tick();
        end
        chk("fl mem_addr_w2", mem_addr, 32'h508);
        mem_rdata = 32'hD2;
        flush     = 1'b1;
        tick();
        flush   = 1'b0;
        mem_ack = 1'b0;
        chk("fl busy", busy, 1'b0);
        chk("fl mem_req", mem_req, 1'b0);
        chk("fl line_valid", line_valid, 1'b0);
        chk("fl refill_err", refill_err, 1'b0);
        tick();
        chk("fl still_no_valid", line_valid, 1'b0);
        chk("fl line_addr kept", line_addr, 32'h1A0);
        $display("flush: busy=%b line_valid=%b", busy, line_valid);
        fill_zero_wait("after_flush", 32'h200, 32'h200, 32'hE0);

        // Second miss while busy must be ignored, including during DONE
        miss_req  = 1'b1;
        miss_addr = 32'h608;
        tick();
        miss_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bm mem_addr_w%0d", i), mem_addr, 32'h600 + 32'(4 * i));
            mem_ack   = 1'b1;
            mem_rdata = 32'hF0 + 32'(i);
            tick();
        end
        mem_ack = 1'b0;
        chk("bm line_valid", line_valid, 1'b1);
        chk("bm line_addr", line_addr, 32'h600);
        chk("bm data_line", data_line, 128'h000000F3_000000F2_000000F1_000000F0);
        tick();
        miss_req = 1'b0;
        chk("bm idle_after_done", busy, 1'b0);
        chk("bm no_req_after_done", mem_req, 1'b0);
        tick();
        chk("bm stays_idle", busy, 1'b0);
        $display("busy miss: line_addr=%h busy=%b", line_addr, busy);

        // Asynchronous reset while fetching word 1
        miss_req  = 1'b1;
        miss_addr = 32'h700;
        tick();
        miss_req  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77;
        tick();
        mem_ack = 1'b0;
        chk("ar pre mem_addr", mem_addr, 32'h704);
        #2 reset_n = 1'b0;
        #1;
        chk("ar mem_req", mem_req, 1'b0);
        chk("ar mem_addr", mem_addr, 32'h0);
        chk("ar busy", busy, 1'b0);
        chk("ar line_addr", line_addr, 32'h0);
        chk("ar data_line", data_line, 128'h0);
        chk("ar line_valid", line_valid, 1'b0);
        $display("async reset: mem_req=%b busy=%b data_line=%h", mem_req, busy, data_line);
        #2 reset_n = 1'b1;
        tick();
        fill_zero_wait("after_reset", 32'h74C, 32'h740, 32'h90);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
